// File: rtl/interp_pkg.sv
// Shared constants, state encoding and helpers for the interpolation tap scheduler.
package interp_pkg;

  localparam int unsigned NTAPS    = 8;
  localparam int unsigned FRAC_W   = 4;
  localparam int unsigned FRAC_MIN = 1;
  localparam int unsigned FRAC_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DONE
  } state_t;

  // Fraction 0 would select the integer position, which this filter array does not produce.
  function automatic logic frac_legal(input logic [FRAC_W-1:0] f);
    return f >= FRAC_W'(FRAC_MIN);
  endfunction

endpackage

// File: rtl/interp_window_sreg.sv
// Sliding sample window: slot DEPTH-1 takes the newest sample, slot 0 holds the oldest.
module interp_window_sreg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en,
  input  logic [DATA_W-1:0]       shift_in,
  output logic [DEPTH*DATA_W-1:0] win_o
);

  logic [DEPTH*DATA_W-1:0] win_q, win_d;

  // Shift the new sample in at the top slot when enabled, otherwise hold.
  always_comb begin
    win_d = win_q;
    if (shift_en) begin
      win_d = {shift_in, win_q[DEPTH*DATA_W-1:DATA_W]};
    end
  end

  // Window storage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/interp_tap_scheduler.sv
// Row sequencer for the 8-tap fractional interpolation filter: primes the sample window,
// then issues one window plus fraction per output position under valid/ready.
module interp_tap_scheduler
  import interp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROW_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [FRAC_W-1:0]       frac,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NTAPS*DATA_W-1:0] out_win,
  output logic [FRAC_W-1:0]       out_frac,
  output logic                    out_last
);

  localparam int unsigned PRIME_W = $clog2(NTAPS);
  localparam int unsigned CNT_W   = $clog2(ROW_W + 1);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(NTAPS - 2);
  localparam logic [CNT_W-1:0]   WIN_LAST   = CNT_W'(ROW_W - 1);

  state_t                  state_q, state_d;
  logic [FRAC_W-1:0]       frac_q, frac_d;
  logic [PRIME_W-1:0]      prime_cnt_q, prime_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [NTAPS*DATA_W-1:0] out_win_q, out_win_d;
  logic                    err_q, err_d;

  logic                    in_ready_c;
  logic                    accept;
  logic                    handshake;
  logic [CNT_W-1:0]        win_idx;
  logic [NTAPS*DATA_W-1:0] win_cur;
  logic [NTAPS*DATA_W-1:0] win_shift;

  assign accept    = in_valid & in_ready_c;
  assign handshake = out_valid_q & out_ready;
  assign win_shift = {in_data, win_cur[NTAPS*DATA_W-1:DATA_W]};
  // Index of the window being accepted: a registered window still outstanding is
  // necessarily handshaking this cycle, so it is counted ahead of out_cnt.
  assign win_idx   = out_cnt_q + CNT_W'(out_valid_q);

  interp_window_sreg #(
    .DATA_W (DATA_W),
    .DEPTH  (NTAPS)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .shift_in (in_data),
    .win_o    (win_cur)
  );

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d     = state_q;
    frac_d      = frac_q;
    prime_cnt_d = prime_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_win_d   = out_win_q;
    err_d       = 1'b0;
    in_ready_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (frac_legal(frac)) begin
            frac_d      = frac;
            prime_cnt_d = '0;
            out_cnt_d   = '0;
            out_last_d  = 1'b0;
            state_d     = PRIME;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PRIME: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          prime_cnt_d = prime_cnt_q + 1'b1;
          if (prime_cnt_q == PRIME_LAST) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        in_ready_c = (!out_valid_q || out_ready) && !out_last_q;
        if (handshake) begin
          out_cnt_d   = out_cnt_q + 1'b1;
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = DONE;
          end
        end
        if (accept) begin
          out_valid_d = 1'b1;
          out_win_d   = win_shift;
          out_last_d  = (win_idx == WIN_LAST);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      frac_q      <= '0;
      prime_cnt_q <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_win_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frac_q      <= frac_d;
      prime_cnt_q <= prime_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_win_q   <= out_win_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q == PRIME) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_win   = out_win_q;
  assign out_frac  = frac_q;

endmodule

// File: tb/tb_interp_tap_scheduler.sv
// Self-checking bench for interp_tap_scheduler: table of row scenarios plus directed
// reset and illegal-start sequences.
module tb_interp_tap_scheduler;

  localparam int DATA_W = 32;
  localparam int NTAPS  = 8;
  localparam int WIN_W  = NTAPS * DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       frac;
  logic             busy, done, err;
  logic             in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic             out_valid, out_ready;
  logic [WIN_W-1:0] out_win;
  logic [3:0]       out_frac;
  logic             out_last;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] frac;
    int         base;
    int         stall_win;
    int         stall_len;
    bit         throttle;
    int         poke;
    int         exp_windows;
    int         exp_samples;
  } row_vec_t;

  row_vec_t vecs[5];

  always #5 clk = ~clk;

  interp_tap_scheduler #(
    .DATA_W (32),
    .ROW_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frac      (frac),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_win   (out_win),
    .out_frac  (out_frac),
    .out_last  (out_last)
  );

  task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one row; entered and left at a negedge.
  task automatic run_row(input row_vec_t v);
    int sent = 0;
    int seen = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int last_hs = -10;
    bit prev_acc_run = 1'b0;
    bit prev_ov = 1'b0;
    bit prev_or = 1'b0;
    bit got_done = 1'b0;
    bit acc;
    bit exp_ov;
    logic [WIN_W-1:0] exp_win;

    @(posedge clk); #1;
    start = 1'b1; frac = v.frac; in_valid = 1'b1; in_data = 32'hBAD0_BAD0; out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; frac = 4'd0;

    while (!got_done && cyc < 300) begin
      in_valid  = v.throttle ? (cyc % 2 == 0) : 1'b1;
      in_data   = in_valid ? 32'(v.base + sent) : 32'hDEAD_BEEF;
      out_ready = !(out_valid && seen == v.stall_win && stall_cnt < v.stall_len);
      start     = (cyc == v.poke);
      frac      = start ? 4'd5 : 4'd0;
      @(negedge clk);
      exp_ov = prev_acc_run | (prev_ov & !prev_or);
      check("out_valid_timing", out_valid, exp_ov);
      check("err_quiet", err, 1'b0);
      if (done) begin
        got_done = 1'b1;
        check("done_window_count", 32'(seen), 32'(v.exp_windows));
        check("done_latency", 32'(cyc), 32'(last_hs + 1));
        check("done_busy", busy, 1'b0);
      end else begin
        check("busy_in_row", busy, 1'b1);
        check("in_ready", in_ready, (sent < v.exp_samples) && (!out_valid || out_ready));
      end
      if (out_valid) begin
        for (int k = 0; k < NTAPS; k++) begin
          exp_win[k*DATA_W +: DATA_W] = 32'(v.base + seen + k);
        end
        check("out_win", out_win, exp_win);
        check("out_last", out_last, seen == v.exp_windows - 1);
        check("out_frac", out_frac, v.frac);
        if (out_ready) begin
          seen++;
          last_hs = cyc;
        end else begin
          stall_cnt++;
        end
      end
      acc = in_valid && in_ready;
      prev_acc_run = acc && (sent >= NTAPS - 1);
      if (acc) sent++;
      prev_ov = out_valid;
      prev_or = out_ready;
      cyc++;
      if (!got_done) begin
        @(posedge clk); #1;
      end
    end
    if (!got_done) begin
      errors++;
      checks++;
      $display("FAIL row_timeout: got no done within %0d cycles, required done", cyc);
    end
    check("samples_accepted", 32'(sent), 32'(v.exp_samples));
    check("stall_cycles", 32'(stall_cnt), 32'(v.stall_len));
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got simulation still running, required finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; frac = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_win", out_win, '0);
    check("rst_out_frac", out_frac, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    //          frac  base stall_win stall_len thr  poke win samp
    vecs[0] = '{4'd8,    1,  -1,       0,      1'b0, -1, 16, 23};
    vecs[1] = '{4'd8,    1,   2,       5,      1'b0, 12, 16, 23};
    vecs[2] = '{4'd3,  100,  -1,       0,      1'b1, -1, 16, 23};
    vecs[3] = '{4'd1,  -16,  15,       3,      1'b0,  4, 16, 23};
    vecs[4] = '{4'd15, 1000, -1,       0,      1'b0, -1, 16, 23};

    for (int i = 0; i < 5; i++) begin
      run_row(vecs[i]);
    end

    // Reset asserted mid-RUN with a window pending under backpressure.
    @(posedge clk); #1;
    start = 1'b1; frac = 4'd8; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'(500 + i);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("mid_run_pending", out_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_out_win", out_win, '0);
    check("midrst_out_frac", out_frac, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_no_done", done, 1'b0);
      check("midrst_idle", busy, 1'b0);
    end

    // Illegal fraction while idle.
    @(posedge clk); #1;
    start = 1'b1; frac = 4'd0; in_valid = 1'b1;
    @(negedge clk);
    check("err_not_early", err, 1'b0);
    check("err_idle_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", err, 1'b1);
    check("err_busy", busy, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_one_cycle", err, 1'b0);
    check("err_still_idle", busy, 1'b0);

    run_row(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
